// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_ARB_TIMEOUT_EN (optional) enables the transfer watchdog in uart_tx_arbiter.
package uart_pkg;

  localparam int CLKS_PER_BIT    = 434;
  localparam int N_REQ_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 6000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the lowest requester at or above ptr wins,
// otherwise the search wraps to the lowest requester overall.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  logic [N_REQ-1:0] mask_s;
  logic [N_REQ-1:0] masked_s;
  logic [N_REQ-1:0] pool_s;

  // Thermometer mask keeps requesters >= ptr; isolate lowest set bit of the chosen pool
  always_comb begin
    mask_s   = ~((N_REQ'(1) << ptr) - N_REQ'(1));
    masked_s = req & mask_s;
    if (|masked_s) begin
      pool_s = masked_s;
    end else begin
      pool_s = req;
    end
    grant = pool_s & (~pool_s + N_REQ'(1));
    valid = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters, round-robin.
// Define UART_ARB_TIMEOUT_EN to add the launch-to-done watchdog and the timeout port.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*8-1:0]       req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  input  logic                     tx_packet_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic [N_REQ-1:0] win_oh_s;
  logic             win_valid_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [7:0]       win_data_s;
  logic [N_REQ-1:0] gnt_nxt_s;
  logic [N_REQ-1:0] done_nxt_s;
  logic             send_nxt_s;
  logic             capture_s;
  logic             finish_s;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr (
    .req  (req),
    .ptr  (ptr_r),
    .grant(win_oh_s),
    .valid(win_valid_s)
  );

  // One-hot winner to index and byte lane; OR-reduction since at most one bit is set
  always_comb begin
    win_idx_s  = '0;
    win_data_s = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      win_idx_s  = win_idx_s | (IDX_W'(i) & {IDX_W{win_oh_s[i]}});
      win_data_s = win_data_s | (req_data[i*8 +: 8] & {8{win_oh_s[i]}});
    end
  end

  // Pointer moves one past the finishing owner, wrapping at N_REQ-1
  always_comb begin
    if (owner == IDX_W'(N_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = owner + IDX_W'(1);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             expire_s;
  logic             timeout_nxt_s;

  assign expire_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog: zero while idle, counts every cycle of an active transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_nxt_s;
      if (state_r == ST_IDLE) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = '0;
    done_nxt_s  = '0;
    send_nxt_s  = 1'b0;
    capture_s   = 1'b0;
    finish_s    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_nxt_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_nxt_s = ST_LAUNCH;
          gnt_nxt_s   = win_oh_s;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_nxt_s = ST_WAIT_DONE;
        send_nxt_s  = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (tx_packet_done) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = N_REQ'(1) << owner;
          finish_s    = 1'b1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (expire_s) begin
          state_nxt_s   = ST_IDLE;
          timeout_nxt_s = 1'b1;
          finish_s      = 1'b1;
        end
`endif
        else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      owner   <= '0;
      tx_data <= 8'h00;
      tx_send <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      gnt     <= gnt_nxt_s;
      done    <= done_nxt_s;
      tx_send <= send_nxt_s;
      busy    <= (state_nxt_s != ST_IDLE);
      if (capture_s) begin
        tx_data <= win_data_s;
        owner   <= win_idx_s;
      end
      if (finish_s) begin
        ptr_r <= ptr_nxt_s;
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL take parameter N_REQ, default 4, number of requesters sharing one UART_TX (2..8).
REQ-002 SHALL take parameter TIMEOUT_CYC, default 6000, max cycles from launch to tx_packet_done (> 12 bit times of 434 clk).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  N_REQ  per-requester byte-send request; held high until gnt.
REQ-007 req_data  input  N_REQ*8  per-requester byte; requester i at bits [8i+7:8i].
REQ-008 gnt  output  N_REQ  one-cycle pulse: requester's byte captured.
REQ-009 done  output  N_REQ  one-cycle pulse: requester's byte fully transmitted.
REQ-010 tx_send  output  1  one-cycle start pulse to UART_TX send.
REQ-011 tx_data  output  8  byte to UART_TX send_data; stable from launch until done.
REQ-012 tx_packet_done  input  1  UART_TX packet_done.
REQ-013 busy  output  1  high from grant until return to IDLE.
REQ-014 owner  output  $clog2(N_REQ)  index of current/last granted requester.
REQ-015 timeout  output  1  one-cycle error pulse (only with UART_ARB_TIMEOUT_EN).

Function
REQ-016 SHALL implement FSM IDLE -> LAUNCH -> WAIT_DONE -> IDLE.
REQ-017 IDLE: if any req bit high, select winner round-robin, latch req_data of winner into tx_data, set owner, pulse gnt[winner], go LAUNCH; else stay.
REQ-018 Round-robin: search starts at pointer, ascending with wrap from N_REQ-1 to 0; pointer = winner+1 (mod N_REQ) on completion.
REQ-019 LAUNCH: tx_send=1 for exactly this one cycle, then WAIT_DONE.
REQ-020 WAIT_DONE: on tx_packet_done=1, pulse done[owner], update pointer, go IDLE next cycle.
REQ-021 Latency: req seen in IDLE at cycle n -> gnt at n, tx_send at n+1; done same cycle as tx_packet_done is sampled +1 register stage.
REQ-022 tx_packet_done in IDLE or LAUNCH SHALL be ignored.
REQ-023 req changes after gnt SHALL not affect the active transfer; req dropped before grant SHALL lose its turn without error.
REQ-024 Single requester continuously asserting SHALL get back-to-back bytes with exactly 1 IDLE cycle between done and next gnt.
REQ-025 At most one gnt, one done bit high per cycle; gnt and done never for same transfer in same cycle.

Reset
REQ-026 On rst: state=IDLE, pointer=0, owner=0, tx_data=0, tx_send=0, gnt=0, done=0, busy=0, timeout=0, timeout counter=0.
REQ-027 rst mid-transfer SHALL abort immediately; no done pulse; first grant after release starts search at requester 0.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: counter runs in LAUNCH/WAIT_DONE; at TIMEOUT_CYC cycles without tx_packet_done, pulse timeout, no done pulse, advance pointer, go IDLE.
REQ-029 Macro undefined: no counter, no timeout port; WAIT_DONE waits indefinitely.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, CLKS_PER_BIT=434, default N_REQ and TIMEOUT_CYC constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (req vector + pointer in, one-hot winner + valid out, combinational).

Verification
REQ-032 rst, then req=4'b0001 data0=8'h62 -> gnt[0] one cycle, tx_send next cycle, tx_data=8'h62; done[0] after UART packet_done (~10 bit times).
REQ-033 req=4'b1111 held, data i=8'h41+i -> grant order 0,1,2,3,0; tx_data sequence 41,42,43,44,41.
REQ-034 After owner=2 completes, req=4'b0011 -> grant 0 then 1 (wrap from pointer 3).
REQ-035 Spurious tx_packet_done pulse while IDLE -> no done, no state change.
REQ-036 rst asserted in WAIT_DONE -> all outputs 0 same cycle; after release req=4'b1000 -> gnt[3], pointer from 0.
REQ-037 UART_ARB_TIMEOUT_EN, UART_TX stubbed never finishing -> timeout pulse at launch+6000 cycles, no done, next requester granted.
